// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU operation codes, forwarding selects, default widths.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_LUI = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/forwarding_unit.sv
// Forwarding select for the EX operands; EX/MEM beats MEM/WB, register 0 never forwarded.
// Latency: combinational. Backpressure: none, pure decode of the current EX/MEM and MEM/WB fields.
// Hazard source: only valid when the EX stage register numbers are stable for the cycle.
module forwarding_unit import mips_pkg::*; #(
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    output fwd_sel_t                  fwd_a,
    output fwd_sel_t                  fwd_b
);

    logic exmem_live;
    logic memwb_live;

    assign exmem_live = exmem_reg_write && (exmem_rd != '0);
    assign memwb_live = memwb_reg_write && (memwb_rd != '0);

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (exmem_live && (exmem_rd == ex_rs)) begin
            fwd_a = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == ex_rs)) begin
            fwd_a = FWD_MEMWB;
        end
        if (exmem_live && (exmem_rd == ex_rt)) begin
            fwd_b = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == ex_rt)) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with load-use (and RAW, without forwarding) stall.
// Latency: 1 cycle ID->ALU inputs; forwarding muxes are combinational from EX/MEM and MEM/WB.
// Backpressure: stall holds PC and IF/ID for one cycle and loads a bubble. Macro ID_EX_FORWARDING_EN.
module id_ex_stage import mips_pkg::*; #(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [3:0]                id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_read_data_1,
    input  logic [DATA_WIDTH-1:0]     id_read_data_2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [4:0]                id_shamt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_alu_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_write_data,
    output logic                      stall,
    output logic [3:0]                ALUOperation,
    output logic [DATA_WIDTH-1:0]     A,
    output logic [DATA_WIDTH-1:0]     B,
    output logic [5:0]                shamt,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]     ex_store_data
);

    typedef struct packed {
        logic                      valid;
        logic [3:0]                alu_op;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     imm;
        logic                      alu_src;
        logic [4:0]                shamt;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      mem_read;
    } idex_t;

    idex_t                 ex_q;
    logic                  bubble;
    logic                  load_use;
    logic                  id_uses_ex_rd;
    logic [DATA_WIDTH-1:0] a_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;

    assign id_uses_ex_rd = (ex_q.rd != '0) && ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
    assign load_use      = ex_q.valid && ex_q.mem_read && id_valid && id_uses_ex_rd;

`ifdef ID_EX_FORWARDING_EN
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
        .ex_rs           (ex_q.rs),
        .ex_rt           (ex_q.rt),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    always_comb begin
        a_fwd  = ex_q.rd1;
        rt_fwd = ex_q.rd2;
        case (fwd_a)
            FWD_EXMEM: a_fwd = exmem_alu_result;
            FWD_MEMWB: a_fwd = memwb_write_data;
            default:   a_fwd = ex_q.rd1;
        endcase
        case (fwd_b)
            FWD_EXMEM: rt_fwd = exmem_alu_result;
            FWD_MEMWB: rt_fwd = memwb_write_data;
            default:   rt_fwd = ex_q.rd2;
        endcase
    end

    assign stall = load_use;
`else
    logic raw_ex;
    logic raw_exmem;
    logic unused_nofwd;

    // Register file writes before it reads, so only EX and EX/MEM producers must be waited out.
    assign raw_ex    = id_valid && ex_q.valid && ex_q.reg_write && id_uses_ex_rd;
    assign raw_exmem = id_valid && exmem_reg_write && (exmem_rd != '0)
                       && ((exmem_rd == id_rs) || (exmem_rd == id_rt));
    assign stall     = load_use || raw_ex || raw_exmem;

    assign a_fwd  = ex_q.rd1;
    assign rt_fwd = ex_q.rd2;

    assign unused_nofwd = ^{exmem_alu_result, memwb_reg_write, memwb_rd, memwb_write_data,
                            ex_q.rs, ex_q.rt};
`endif

    assign bubble = reset || flush || stall;

    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_q <= '0;
        end else begin
            ex_q <= '{valid:     id_valid,
                      alu_op:    id_alu_op,
                      rd1:       id_read_data_1,
                      rd2:       id_read_data_2,
                      imm:       id_imm,
                      alu_src:   id_alu_src,
                      shamt:     id_shamt,
                      rs:        id_rs,
                      rt:        id_rt,
                      rd:        id_rd,
                      reg_write: id_reg_write,
                      mem_read:  id_mem_read};
        end
    end

    assign ALUOperation  = ex_q.alu_op;
    assign A             = a_fwd;
    assign B             = ex_q.alu_src ? ex_q.imm : rt_fwd;
    assign shamt         = {1'b0, ex_q.shamt};
    assign ex_store_data = rt_fwd;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected ALU inputs, a negedge monitor pops them.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  id_alu_op;
    logic [31:0] id_read_data_1, id_read_data_2, id_imm;
    logic        id_alu_src;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic        id_reg_write, id_mem_read, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_alu_result, memwb_write_data;
    logic        stall;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B, ex_store_data;
    logic [5:0]  shamt;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_write_data(memwb_write_data),
        .stall(stall), .ALUOperation(ALUOperation), .A(A), .B(B), .shamt(shamt),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  sh;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [31:0] sd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ex_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got op=%0h A=%0h B=%0h expected no instruction",
                             ALUOperation, A, B);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("txn%0d_op", e.id), ALUOperation, e.op);
                    chk($sformatf("txn%0d_A", e.id), A, e.a);
                    chk($sformatf("txn%0d_B", e.id), B, e.b);
                    chk($sformatf("txn%0d_ctl", e.id), {shamt, ex_rd, ex_reg_write, ex_mem_read, ex_store_data},
                        {e.sh, e.rd, e.rw, e.mr, e.sd});
                end
            end else begin
                chk("bubble_zero", {ex_valid, ALUOperation, A, B, shamt, ex_reg_write, ex_mem_read, ex_rd, ex_store_data}, '0);
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sh, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [31:0] sd);
        sb.push_back('{id: txn, op: op, a: a, b: b, sh: sh, rd: rd, rw: rw, mr: mr, sd: sd});
        txn++;
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_alu_op = '0; id_read_data_1 = '0; id_read_data_2 = '0; id_imm = '0;
        id_alu_src = 1'b0; id_shamt = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_alu_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_write_data = '0;
    endtask

    task automatic rand_inputs();
        flush = 1'($urandom); id_valid = 1'($urandom); id_alu_op = 4'($urandom);
        id_read_data_1 = $urandom; id_read_data_2 = $urandom; id_imm = $urandom;
        id_alu_src = 1'($urandom); id_shamt = 5'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        exmem_reg_write = 1'b0; exmem_rd = 5'($urandom); exmem_alu_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom); memwb_write_data = $urandom;
    endtask

    task automatic set_id(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic src, input logic [4:0] sh,
                          input logic rw, input logic mr);
        id_valid = 1'b1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_read_data_1 = r1; id_read_data_2 = r2; id_imm = imm; id_alu_src = src;
        id_shamt = sh; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic set_exmem(input logic [4:0] rd, input logic [31:0] res);
        exmem_reg_write = 1'b1; exmem_rd = rd; exmem_alu_result = res;
    endtask

    task automatic set_memwb(input logic [4:0] rd, input logic [31:0] dat);
        memwb_reg_write = 1'b1; memwb_rd = rd; memwb_write_data = dat;
    endtask

    task automatic next();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic cs(input logic exp, input string name);
        #1;
        chk(name, stall, exp);
    endtask

    initial begin
        // Reset held for two edges under random stimulus.
        reset = 1'b1;
        rand_inputs();
        @(posedge clk); #1;
        mon_en = 1'b1;
        rand_inputs();
        cs(1'b0, "reset_stall_a");
        @(posedge clk); #1;
        rand_inputs();
        cs(1'b0, "reset_stall_b");
        next();

        // Back-to-back RAW: add r3 then sub r6 = r3 - r4.
        next(); set_id(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'h7, 32'h9, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_ADD, 32'h7, 32'h9, 6'd0, 5'd3, 1'b1, 1'b0, 32'h9);
        cs(1'b0, "raw_add_issue");
`ifdef ID_EX_FORWARDING_EN
        next(); set_id(ALU_SUB, 5'd3, 5'd4, 5'd6, 32'h55, 32'h4, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_SUB, 32'h10, 32'h4, 6'd0, 5'd6, 1'b1, 1'b0, 32'h4);
        cs(1'b0, "raw_no_stall");
        next(); set_exmem(5'd3, 32'h10);
        cs(1'b0, "raw_sub_ex");
`else
        next(); set_id(ALU_SUB, 5'd3, 5'd4, 5'd6, 32'h55, 32'h4, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        cs(1'b1, "raw_stall_1");
        next(); set_id(ALU_SUB, 5'd3, 5'd4, 5'd6, 32'h55, 32'h4, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        set_exmem(5'd3, 32'h10);
        cs(1'b1, "raw_stall_2");
        next(); set_id(ALU_SUB, 5'd3, 5'd4, 5'd6, 32'h10, 32'h4, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        set_memwb(5'd3, 32'h10);
        push(ALU_SUB, 32'h10, 32'h4, 6'd0, 5'd6, 1'b1, 1'b0, 32'h4);
        cs(1'b0, "raw_release");
        next();
`endif

        // Double hazard on r5: EX/MEM must win over MEM/WB.
        next(); set_id(ALU_OR, 5'd5, 5'd8, 5'd7, 32'h11, 32'h22, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
`ifdef ID_EX_FORWARDING_EN
        push(ALU_OR, 32'hAA, 32'h22, 6'd0, 5'd7, 1'b1, 1'b0, 32'h22);
`else
        push(ALU_OR, 32'h11, 32'h22, 6'd0, 5'd7, 1'b1, 1'b0, 32'h22);
`endif
        cs(1'b0, "dh_issue");
        next(); set_exmem(5'd5, 32'hAA); set_memwb(5'd5, 32'hBB);

        // Writers targeting r0 never forward.
        next(); set_id(ALU_OR, 5'd0, 5'd9, 5'd7, 32'h33, 32'h44, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_OR, 32'h33, 32'h44, 6'd0, 5'd7, 1'b1, 1'b0, 32'h44);
        next(); set_exmem(5'd0, 32'hAA); set_memwb(5'd0, 32'hBB);

        // MEM/WB-only match on the rt path.
        next(); set_id(ALU_ADD, 5'd10, 5'd9, 5'd7, 32'h1, 32'h44, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
`ifdef ID_EX_FORWARDING_EN
        push(ALU_ADD, 32'h1, 32'hCC, 6'd0, 5'd7, 1'b1, 1'b0, 32'hCC);
`else
        push(ALU_ADD, 32'h1, 32'h44, 6'd0, 5'd7, 1'b1, 1'b0, 32'h44);
`endif
        next(); set_exmem(5'd4, 32'hAA); set_memwb(5'd9, 32'hCC);

        // Load-use: lw r4 then add r9 = r4 + r2.
        next(); set_id(ALU_ADD, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1'b1, 5'd0, 1'b1, 1'b1);
        push(ALU_ADD, 32'h100, 32'h8, 6'd0, 5'd4, 1'b1, 1'b1, 32'h0);
        cs(1'b0, "lu_issue");
        next(); set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h0, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        cs(1'b1, "lu_stall");
        next(); set_exmem(5'd4, 32'h108);
        chk("lu_bubble_valid", ex_valid, 1'b0);
`ifdef ID_EX_FORWARDING_EN
        set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h0, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_ADD, 32'h77, 32'h3, 6'd0, 5'd9, 1'b1, 1'b0, 32'h3);
        cs(1'b0, "lu_release");
`else
        set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h0, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        cs(1'b1, "lu_stall_exmem");
        next(); set_memwb(5'd4, 32'h77);
        set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h77, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_ADD, 32'h77, 32'h3, 6'd0, 5'd9, 1'b1, 1'b0, 32'h3);
        cs(1'b0, "lu_release");
`endif
        next(); set_memwb(5'd4, 32'h77);

        // Flush coinciding with a load-use hazard.
        next(); set_id(ALU_ADD, 5'd1, 5'd0, 5'd4, 32'h200, 32'h0, 32'h4, 1'b1, 5'd0, 1'b1, 1'b1);
        push(ALU_ADD, 32'h200, 32'h4, 6'd0, 5'd4, 1'b1, 1'b1, 32'h0);
        next(); set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h0, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        flush = 1'b1;
        cs(1'b1, "fl_stall");
        next(); set_exmem(5'd4, 32'h204);
        chk("fl_bubble_valid", ex_valid, 1'b0);
        set_id(ALU_OR, 5'd11, 5'd12, 5'd10, 32'h5, 32'h6, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_OR, 32'h5, 32'h6, 6'd0, 5'd10, 1'b1, 1'b0, 32'h6);
        cs(1'b0, "fl_after");
        next();

        // Shift amount and immediate B operand.
        next(); set_id(ALU_SLL, 5'd0, 5'd2, 5'd5, 32'h0, 32'h1, 32'h0, 1'b0, 5'd31, 1'b1, 1'b0);
        push(ALU_SLL, 32'h0, 32'h1, 6'd31, 5'd5, 1'b1, 1'b0, 32'h1);
        cs(1'b0, "sll_issue");
        next(); set_id(ALU_LUI, 5'd0, 5'd8, 5'd8, 32'h0, 32'hDEAD, 32'h1234, 1'b1, 5'd0, 1'b1, 1'b0);
`ifdef ID_EX_FORWARDING_EN
        push(ALU_LUI, 32'h0, 32'h1234, 6'd0, 5'd8, 1'b1, 1'b0, 32'h999);
`else
        push(ALU_LUI, 32'h0, 32'h1234, 6'd0, 5'd8, 1'b1, 1'b0, 32'hDEAD);
`endif
        cs(1'b0, "lui_issue");
        next(); set_exmem(5'd8, 32'h999);

        // Reset arriving while a load-use stall is pending.
        next(); set_id(ALU_ADD, 5'd1, 5'd0, 5'd4, 32'h300, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 1'b1);
        push(ALU_ADD, 32'h300, 32'h0, 6'd0, 5'd4, 1'b1, 1'b1, 32'h0);
        next(); set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h40, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        reset = 1'b1;
        cs(1'b1, "rst_mid_stall");
        next(); set_id(ALU_ADD, 5'd4, 5'd2, 5'd9, 32'h40, 32'h3, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
        push(ALU_ADD, 32'h40, 32'h3, 6'd0, 5'd9, 1'b1, 1'b0, 32'h3);
        cs(1'b0, "rst_released");
        next();
        next();
        next();
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that feeds the 32-bit ALU. It registers decoded operands and controls on each clock. It resolves data hazards by forwarding from the EX/MEM and MEM/WB stages and by detecting load-use conflicts. It outputs `ALUOperation`, `A`, `B` and `shamt` directly to the ALU's input ports, with one-cycle stall and flush control back to the IF/ID stage.

## Interface
- `DATA_WIDTH`, 32, operand width
- `REG_ADDR_WIDTH`, 5, register-file address width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `id_valid`  in  1  ID holds a real instruction
- `id_alu_op`  in  4  ALU operation code from ALU control
- `id_read_data_1` / `id_read_data_2`  in  32  register-file rs / rt values
- `id_imm`  in  32  sign-extended immediate
- `id_alu_src`  in  1  1: B takes immediate; 0: B takes rt value
- `id_shamt`  in  5  instruction shamt field
- `id_rs`, `id_rt`, `id_rd`  in  5  source and destination register numbers
- `id_reg_write`, `id_mem_read`  in  1  control bits for the instruction
- `flush`  in  1  taken branch/jump; squash the ID instruction
- `exmem_reg_write`  in  1; `exmem_rd`  in  5; `exmem_alu_result`  in  32
- `memwb_reg_write`  in  1; `memwb_rd`  in  5; `memwb_write_data`  in  32
- `stall`  out  1  hold PC and IF/ID this cycle (combinational)
- `ALUOperation`  out  4; `A`  out  32; `B`  out  32; `shamt`  out  6  ALU inputs
- `ex_valid`, `ex_reg_write`, `ex_mem_read`  out  1  registered controls
- `ex_rd`  out  5  registered destination
- `ex_store_data`  out  32  forwarded rt value, used for stores

## Operation
- Pipeline register updates every cycle. No enable. Upstream holds the instruction during `stall`.
- Load condition: not `stall`, not `flush`. Register `id_*` payload and set `ex_valid = id_valid`.
- Bubble condition: `stall` or `flush` or `reset`. Load zeros, so `ex_valid`, `ex_reg_write` and `ex_mem_read` are 0 and `ALUOperation` is 4'b0000 (AND).
- `flush` and `stall` together: bubble (flush dominates; same effect).
- `shamt` is the registered `id_shamt` zero-extended to 6 bits.
- Forwarding is combinational on registered `ex_rs`/`ex_rt`. This applies to operand A and to the rt path (B when `alu_src`=0, and `ex_store_data`):
  - EX/MEM match (`exmem_reg_write`, `exmem_rd` ≠ 0, equal to the operand's register): use `exmem_alu_result`.
  - Otherwise MEM/WB match (same rules): use `memwb_write_data`.
  - Otherwise use the registered register-file value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- `B` = registered `id_imm` when the registered `alu_src` = 1, else the forwarded rt value.
- Load-use stall: `stall` = `ex_valid` & `ex_mem_read` & `id_valid` & (`ex_rd` ≠ 0) & (`ex_rd` = `id_rs` or `ex_rd` = `id_rt`).
  - The inserted bubble clears `ex_mem_read`, so the stall lasts exactly 1 cycle.

## Timing
- Latency: an ID instruction appears on the ALU inputs 1 cycle after the edge that accepts it.
- Reset: all registered outputs are 0 on the first edge with `reset` = 1. `stall` is 0 while EX holds a bubble.
- Forwarding muxes add a combinational path from `exmem_*`/`memwb_*` to `A`/`B`. There are no internal cycles of delay.
- Reset asserted mid-stall: the next edge produces a bubble and `stall` deasserts.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding as above.
- `ID_EX_FORWARDING_EN` undefined: no forwarding muxes; `A`, `B` and `ex_store_data` are always the registered values.
  - `stall` additionally asserts for any `id_valid` instruction whose `id_rs`/`id_rt` (≠ 0) matches either:
    - `ex_rd` with `ex_valid` & `ex_reg_write`, or
    - `exmem_rd` with `exmem_reg_write`.
  - The register file is write-before-read, so MEM/WB needs no stall.
  - A RAW stall lasts up to 2 cycles.

## Structure
- Shared package `mips_pkg`:
  - ALU op constants: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, LUI 0101, SLL 0110, SRL 0111.
  - 2-bit forwarding-select enum: FWD_REG, FWD_MEMWB, FWD_EXMEM.
  - `DATA_WIDTH` and `REG_ADDR_WIDTH` defaults.
- One sub-module `forwarding_unit`: computes the two forwarding selects from `ex_rs`, `ex_rt` and the EX/MEM and MEM/WB fields. It is instantiated only under `ID_EX_FORWARDING_EN`.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> all outputs 0, `stall` = 0.
- Back-to-back RAW: `add r3` (ADD, result 0x10) followed by `sub` reading r3, with `exmem_rd` = 3 and `exmem_alu_result` = 0x10 -> `A` = 0x10 and `ALUOperation` = 0100 in the `sub` EX cycle; `stall` never asserts.
- Double hazard: EX/MEM r5 = 0xAA and MEM/WB r5 = 0xBB, both writing -> `A` = 0xAA. Same case with rd = 0 -> `A` = register-file value.
- Load-use: `lw r4` in EX (`ex_mem_read` = 1), ID reads r4 -> `stall` = 1 for exactly 1 cycle; next EX cycle is a bubble (`ex_valid` = 0, op 0000); dependent op enters EX one cycle later.
- Flush during stall: `flush` = 1 and a load-use hazard in the same cycle -> bubble loaded; the following cycle has `stall` = 0.
- Shift and immediate: SLL with `id_shamt` = 31 -> `shamt` = 6'd31. LUI with `id_alu_src` = 1 and `id_imm` = 0x00001234 -> `B` = 0x00001234. With the macro undefined, a RAW dependence at distance 1 -> `stall` = 1 for 2 cycles.
